// File: rtl/m6809_mem16_xfer.sv
// m6809_mem16_xfer: 16-bit big-endian load/store sequencer between the
// 8-bit data bus and alu16.
//
// Loads read the MSB at ea, then the LSB at ea+1, and assemble the word on rdata.
// Stores write wdata[15:8] to ea, then wdata[7:0] to ea+1.
//
// Optional feature (macro M6809_MEM16_WAIT_EN):
//   defined   - a bus cycle completes only on a posedge with mem_ready=1
//   undefined - mem_ready is ignored and every bus cycle takes one clock
//
// Ports:
//   clk, reset_b           clock; synchronous active-low reset
//   start, is_store        begin a transfer (sampled in IDLE); direction
//   ea, wdata              effective address and store data, latched on start
//   busy, done             transfer in flight; one-cycle completion pulse
//   rdata                  assembled load word (feeds the alu16 operand input)
//   mem_addr, mem_dout     registered bus address and write data
//   mem_din                bus read data
//   mem_rd, mem_wr         registered bus strobes
//   mem_ready              bus cycle complete

module m6809_mem16_xfer #(
  parameter int          ADDR_W    = 16,
  parameter logic [15:0] RDATA_RST = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] ea,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] ea_q;
  logic [ADDR_W-1:0] ea_d;
  logic [15:0]       wdata_q;
  logic [15:0]       wdata_d;
  logic              st_q;
  logic              st_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        dout_q;
  logic [7:0]        dout_d;
  logic              rd_q;
  logic              rd_d;
  logic              wr_q;
  logic              wr_d;
  logic [15:0]       rdata_q;
  logic [15:0]       rdata_d;

  logic              bus_ok;
  logic [ADDR_W-1:0] ea_nxt;

`ifdef M6809_MEM16_WAIT_EN
  assign bus_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign bus_ok = 1'b1;
`endif

  // Second byte address; wraps naturally at the top of the address space.
  assign ea_nxt = ea_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      ea_q    <= '0;
      wdata_q <= '0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= RDATA_RST;
    end else begin
      state_q <= state_d;
      ea_q    <= ea_d;
      wdata_q <= wdata_d;
      st_q    <= st_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs are computed one cycle ahead so they leave the block
  // straight from flops, aligned with the state they belong to.
  always_comb begin
    state_d = state_q;
    ea_d    = ea_q;
    wdata_d = wdata_q;
    st_d    = st_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        dout_d = '0;
        if (start) begin
          ea_d    = ea;
          wdata_d = wdata;
          st_d    = is_store;
          state_d = S_HI;
          addr_d  = ea;
          rd_d    = !is_store;
          wr_d    = is_store;
          dout_d  = is_store ? wdata[15:8] : 8'h00;
        end
      end
      S_HI: begin
        if (bus_ok) begin
          if (!st_q) begin
            rdata_d[15:8] = mem_din;
          end
          state_d = S_LO;
          addr_d  = ea_nxt;
          rd_d    = !st_q;
          wr_d    = st_q;
          dout_d  = st_q ? wdata_q[7:0] : 8'h00;
        end
      end
      S_LO: begin
        if (bus_ok) begin
          if (!st_q) begin
            rdata_d[7:0] = mem_din;
          end
          state_d = S_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          dout_d  = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign rdata    = rdata_q;
  assign mem_addr = addr_q;
  assign mem_dout = dout_q;
  assign mem_rd   = rd_q;
  assign mem_wr   = wr_q;

endmodule

// File: tb/tb_m6809_mem16_xfer.sv
// tb_m6809_mem16_xfer: scoreboard bench for m6809_mem16_xfer.
// Directed transfers; a negedge monitor checks bus cycles and done pulses.

module tb_m6809_mem16_xfer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [15:0] ea = '0;
  logic [15:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ready = 1'b1;

  m6809_mem16_xfer #(
    .ADDR_W(16),
    .RDATA_RST(16'h0000)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .start(start),
    .is_store(is_store),
    .ea(ea),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .mem_din(mem_din),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:65535];
  assign mem_din = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr && mem_ready) mem[mem_addr] <= mem_dout;
  end

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } bus_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic [31:0] cyc;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];
  bus_t  mon_b;
  done_t mon_d;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (mem_rd || mem_wr) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: got rd=%b wr=%b addr=%h expected none",
                 mem_rd, mem_wr, mem_addr);
      end else begin
        mon_b = bus_q[0];
        check("bus_wr", {31'd0, mem_wr}, {31'd0, mon_b.wr});
        check("bus_rd", {31'd0, mem_rd}, {31'd0, !mon_b.wr});
        check("bus_addr", {16'd0, mem_addr}, {16'd0, mon_b.addr});
        if (mon_b.wr) check("bus_dout", {24'd0, mem_dout}, {24'd0, mon_b.data});
        if (mem_ready) void'(bus_q.pop_front());
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 at cycle %0d expected none", cyc);
      end else begin
        mon_d = done_q.pop_front();
        check("done_rdata", {16'd0, rdata}, {16'd0, mon_d.rdata});
        check("done_cycle", cyc, mon_d.cyc);
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle
  // directly after DONE, so consecutive calls run back-to-back.
  task automatic issue(input logic st, input logic [15:0] a,
                       input logic [15:0] wd, input int waits,
                       input logic [15:0] exp_rd);
    logic [15:0] a1;
    a1 = a + 16'd1;
    start = 1'b1;
    is_store = st;
    ea = a;
    wdata = wd;
    mem_ready = (waits == 0);
    bus_q.push_back({st, a, st ? wd[15:8] : 8'h00});
    bus_q.push_back({st, a1, st ? wd[7:0] : 8'h00});
    done_q.push_back({exp_rd, cyc + 32'd3 + 32'(waits)});
    @(negedge clk);
    start = 1'b0;
    repeat (waits) @(negedge clk);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] d;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1000] = 8'hAB;
    mem[16'h1001] = 8'hCD;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hC3;
    mem[16'h4000] = 8'h11;
    mem[16'h4001] = 8'h22;
    mem[16'h5000] = 8'h55;
    mem[16'h5001] = 8'h66;
    mem[16'h3000] = 8'hEE;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    reset_b = 1'b1;
    @(negedge clk);

    issue(1'b0, 16'h1000, 16'h0000, 0, 16'hABCD);
    issue(1'b1, 16'h2000, 16'h1234, 0, 16'hABCD);
    issue(1'b0, 16'hFFFF, 16'h0000, 0, 16'h5AC3);

    // Reset while in LO: both reads appear, no done follows.
    start = 1'b1;
    is_store = 1'b0;
    ea = 16'h6000;
    bus_q.push_back({1'b0, 16'h6000, 8'h00});
    bus_q.push_back({1'b0, 16'h6001, 8'h00});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rd", {31'd0, mem_rd}, 32'd0);
    check("midrst_rdata", {16'd0, rdata}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset_b = 1'b1;
    @(negedge clk);
    issue(1'b1, 16'h7000, 16'hBEEF, 0, 16'h0000);

    // Start pulsed during HI is ignored; start held from DONE into IDLE
    // is taken on the IDLE edge.
    start = 1'b1;
    is_store = 1'b0;
    ea = 16'h4000;
    bus_q.push_back({1'b0, 16'h4000, 8'h00});
    bus_q.push_back({1'b0, 16'h4001, 8'h00});
    done_q.push_back({16'h1122, cyc + 32'd3});
    @(negedge clk);
    ea = 16'h3000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    d = cyc;
    start = 1'b1;
    ea = 16'h5000;
    bus_q.push_back({1'b0, 16'h5000, 8'h00});
    bus_q.push_back({1'b0, 16'h5001, 8'h00});
    done_q.push_back({16'h5566, d + 32'd4});
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    issue(1'b0, 16'h2000, 16'h0000, 0, 16'h1234);
    issue(1'b0, 16'h7000, 16'h0000, 0, 16'hBEEF);

`ifdef M6809_MEM16_WAIT_EN
    issue(1'b0, 16'h1000, 16'h0000, 2, 16'hABCD);
    issue(1'b1, 16'h8000, 16'hCAFE, 1, 16'hABCD);
    issue(1'b0, 16'h8000, 16'h0000, 0, 16'hCAFE);
`endif

    repeat (3) @(negedge clk);
    check("bus_q_empty", bus_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    check("end_idle", {31'd0, busy}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
